// File: rtl/counter_cmd_seq.sv
// rtl/counter_cmd_seq.sv - synchronise, debounce and sequence raw buttons into counter commands
// Optional auto-repeat of held up/down buttons: define COUNTER_CMD_AUTOREPEAT_EN.
module counter_cmd_seq #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_load,
   input  logic [WIDTH-1:0] sw_val,
   output logic             enable,
   output logic             up,
   output logic             load,
   output logic [WIDTH-1:0] cnt_in,
   output logic             busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam int B_UP   = 0;
   localparam int B_DOWN = 1;
   localparam int B_LOAD = 2;

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;
   typedef enum logic [1:0] {CMD_UP, CMD_DOWN, CMD_LOAD} cmd_t;

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("counter_cmd_seq: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
   end

   state_t           state, state_nxt;
   cmd_t             cmd_q;
   logic [2:0]       btn_s1, btn_s2, btn_deb, btn_deb_d, btn_rise;
   logic [WIDTH-1:0] sw_s1, sw_s2, cnt_in_q;
   logic             up_q;
   logic             take_cmd;
   logic             rep_fire;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_s1    <= '0;
         btn_s2    <= '0;
         sw_s1     <= '0;
         sw_s2     <= '0;
         btn_deb_d <= '0;
      end else begin
         btn_s1    <= {btn_load, btn_down, btn_up};
         btn_s2    <= btn_s1;
         sw_s1     <= sw_val;
         sw_s2     <= sw_s1;
         btn_deb_d <= btn_deb;
      end
   end

   // The level only flips after DEBOUNCE_CYCLES consecutive differing samples.
   for (genvar i = 0; i < 3; i++) begin : g_db
      logic          deb_q;
      logic [DW-1:0] cnt_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
         end else if (btn_s2[i] == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            deb_q <= btn_s2[i];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DW'(1);
         end
      end

      assign btn_deb[i] = deb_q;
   end

   assign btn_rise = btn_deb & ~btn_deb_d;
   assign take_cmd = (state == IDLE) && (btn_rise != 3'b000);

`ifdef COUNTER_CMD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_ok;

   assign rep_ok   = (state == HOLD) && ((btn_deb == 3'b001) || (btn_deb == 3'b010));
   assign rep_fire = rep_ok && (rep_cnt == REP_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rep_cnt <= '0;
      end else if (!rep_ok || rep_fire) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command, direction and load value are latched on the edge that enters PULSE,
   // so the counter sees the new direction in the same cycle as the pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cmd_q    <= CMD_UP;
         up_q     <= 1'b1;
         cnt_in_q <= '0;
      end else if (take_cmd) begin
         if (btn_rise[B_LOAD]) begin
            cmd_q    <= CMD_LOAD;
            cnt_in_q <= sw_s2;
         end else if (btn_rise[B_UP]) begin
            cmd_q <= CMD_UP;
            up_q  <= 1'b1;
         end else begin
            cmd_q <= CMD_DOWN;
            up_q  <= 1'b0;
         end
      end else if (rep_fire) begin
         up_q <= btn_deb[B_UP];
      end
   end

   always_comb begin
      state_nxt = state;
      enable    = 1'b0;
      load      = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (btn_rise != 3'b000) begin
               state_nxt = PULSE;
            end
         end
         PULSE: begin
            enable    = (cmd_q != CMD_LOAD);
            load      = (cmd_q == CMD_LOAD);
            state_nxt = HOLD;
         end
         HOLD: begin
            enable = rep_fire;
            if (btn_deb == 3'b000) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign up     = up_q;
   assign cnt_in = cnt_in_q;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// tb/tb_counter_cmd_seq.sv - scoreboard bench for counter_cmd_seq (default build, DEBOUNCE_CYCLES=4)
module tb_counter_cmd_seq;

   localparam int W = 4;
   localparam int D = 4;

   logic         clock    = 1'b0;
   logic         reset    = 1'b0;
   logic         btn_up   = 1'b0;
   logic         btn_down = 1'b0;
   logic         btn_load = 1'b0;
   logic [W-1:0] sw_val   = '0;
   logic         enable, up, load, busy;
   logic [W-1:0] cnt_in;

   always #5 clock = ~clock;

   counter_cmd_seq #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (8)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .btn_up  (btn_up),
      .btn_down(btn_down),
      .btn_load(btn_load),
      .sw_val  (sw_val),
      .enable  (enable),
      .up      (up),
      .load    (load),
      .cnt_in  (cnt_in),
      .busy    (busy)
   );

   typedef struct {int cyc; bit is_load; bit up; logic [W-1:0] cnt;} ev_t;
   typedef struct {int cyc; bit busy; bit up; logic [W-1:0] cnt;} st_t;

   ev_t ev_q[$];
   st_t st_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference: sample k reaches the debouncer two edges later; a level flips once
   // D consecutive delayed samples disagree with it. A command issues on a debounced
   // rise while idle, then nothing more until every debounced button is low.
   initial begin : model
      logic [2:0]   sq[$];
      logic [W-1:0] wq[$];
      logic [2:0]   deb, deb_p1, nd, rise;
      bit           all_diff;
      int           phase;
      bit           m_up;
      logic [W-1:0] m_cnt;
      st_t          st;
      ev_t          ev;
      deb = '0; deb_p1 = '0; phase = 0; m_up = 1'b1; m_cnt = '0;
      forever begin
         @(posedge clock);
         cyc++;
         if (!reset) begin
            sq.delete();
            wq.delete();
            for (int i = 0; i < D + 4; i++) begin
               sq.push_back(3'b000);
               wq.push_back('0);
            end
            deb = '0; deb_p1 = '0; phase = 0; m_up = 1'b1; m_cnt = '0;
         end else begin
            sq.push_back({btn_load, btn_down, btn_up});
            wq.push_back(sw_val);
            if (sq.size() > D + 4) begin
               void'(sq.pop_front());
               void'(wq.pop_front());
            end
            rise = deb & ~deb_p1;
            if (phase == 0 && rise != 3'b000) begin
               if (rise[2]) m_cnt = wq[wq.size() - 3];
               else         m_up  = rise[0];
               ev.cyc = cyc; ev.is_load = rise[2]; ev.up = m_up; ev.cnt = m_cnt;
               ev_q.push_back(ev);
               phase = 1;
            end else if (phase == 1) begin
               phase = 2;
            end else if (phase == 2 && deb == 3'b000) begin
               phase = 0;
            end
            for (int b = 0; b < 3; b++) begin
               all_diff = 1'b1;
               for (int j = 0; j < D; j++)
                  if (sq[sq.size() - 3 - j][b] == deb[b]) all_diff = 1'b0;
               nd[b] = all_diff ? ~deb[b] : deb[b];
            end
            deb_p1 = deb;
            deb    = nd;
         end
         st.cyc = cyc; st.busy = (phase != 0); st.up = m_up; st.cnt = m_cnt;
         st_q.push_back(st);
      end
   end

   initial begin : monitor
      st_t st;
      ev_t ev;
      forever begin
         @(negedge clock);
         if (st_q.size() == 0) begin
            check("status_queue", 0, 1);
            continue;
         end
         st = st_q.pop_front();
         if (!reset) begin
            check("rst_enable", enable, 0);
            check("rst_load", load, 0);
            check("rst_busy", busy, 0);
            check("rst_up", up, 1);
            check("rst_cnt_in", cnt_in, 0);
            if (ev_q.size() != 0 && ev_q[0].cyc == st.cyc) void'(ev_q.pop_front());
         end else begin
            check("busy", busy, st.busy);
            check("up", up, st.up);
            check("cnt_in", cnt_in, st.cnt);
            check("enable_load_exclusive", enable & load, 0);
            if (enable | load) begin
               if (ev_q.size() == 0) begin
                  check("unexpected_pulse", {enable, load}, 0);
               end else begin
                  ev = ev_q.pop_front();
                  check("pulse_cycle", st.cyc, ev.cyc);
                  check("pulse_load", load, ev.is_load);
                  check("pulse_enable", enable, !ev.is_load);
               end
            end else if (ev_q.size() != 0 && ev_q[0].cyc <= st.cyc) begin
               ev = ev_q.pop_front();
               check("missed_pulse", 0, 1);
            end
         end
      end
   end

   task automatic drive(input logic u, input logic d, input logic l,
                        input logic [W-1:0] s, input int n);
      btn_up = u; btn_down = d; btn_load = l; sw_val = s;
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   initial begin : stim
      repeat (5) @(posedge clock);
      #2;
      reset = 1'b1;
      drive(0, 0, 0, 4'h0, 100);
      // up press and release
      drive(1, 0, 0, 4'h0, 40);
      drive(0, 0, 0, 4'h0, 20);
      // down glitch, clean down, then load keeps direction
      drive(0, 1, 0, 4'h0, 3);
      drive(0, 0, 0, 4'h0, 10);
      drive(0, 1, 0, 4'h0, 20);
      drive(0, 0, 0, 4'h0, 20);
      drive(0, 0, 1, 4'h5, 20);
      drive(0, 0, 0, 4'h5, 20);
      // load value held after the switches move
      drive(0, 0, 0, 4'hA, 10);
      drive(0, 0, 1, 4'hA, 20);
      drive(0, 0, 0, 4'hA, 10);
      drive(0, 0, 0, 4'h3, 20);
      // simultaneous load+up, then down during HOLD
      drive(1, 0, 1, 4'h6, 15);
      drive(1, 1, 1, 4'h6, 15);
      drive(0, 0, 0, 4'h6, 20);
      // reset asserted during the PULSE cycle
      drive(1, 0, 0, 4'h0, 7);
      reset = 1'b0;
      drive(0, 0, 0, 4'h0, 3);
      reset = 1'b1;
      drive(0, 0, 0, 4'h0, 20);
      // random presses, glitches and overlaps
      for (int i = 0; i < 200; i++)
         drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), W'($urandom), $urandom_range(1, 12));
      drive(0, 0, 0, 4'h0, 30);
      @(negedge clock);
      #1;
      check("pending_pulses", ev_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
